// File: rtl/led_cmd_tx.sv
// LED command serializer: shifts a 7-bit {inst, addr} word to an LED
// receiver, strobes the latch, and generates a free-running blink wave.
module led_cmd_tx #(
    parameter int CLK_DIV = 4,
    parameter int PAT_DIV = 1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [4:0] CMD_ADDR,
    input  logic [1:0] CMD_INST,
    output logic       SCLK_OUT,
    output logic       SDATA_OUT,
    output logic       LATCH_OUT,
    output logic       PATTERN_OUT,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        GAP
    } state_t;

    localparam logic [8:0]  HALF_END = 9'(CLK_DIV - 1);
    localparam logic [8:0]  FULL_END = 9'(2 * CLK_DIV - 1);
    localparam logic [23:0] PAT_END  = 24'(PAT_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'd6;

    state_t      state;
    state_t      state_nx;
    logic [8:0]  cnt;
    logic [8:0]  cnt_nx;
    logic [2:0]  bidx;
    logic [2:0]  bidx_nx;
    logic [6:0]  word;
    logic [6:0]  word_nx;
    logic        sclk_nx;
    logic        sdata_nx;
    logic        latch_nx;
    logic        done_nx;
    logic        ready_nx;
    logic        half_hit;
    logic        full_hit;
    logic [23:0] pcnt;

    assign half_hit = (cnt == HALF_END);
    assign full_hit = (cnt == FULL_END);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (full_hit && bidx == LAST_BIT) begin
                    state_nx = LATCH;
                end
            end
            LATCH: begin
                if (full_hit) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (half_hit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of every registered output and datapath register.
    always_comb begin
        cnt_nx   = cnt + 9'd1;
        bidx_nx  = bidx;
        word_nx  = word;
        sclk_nx  = SCLK_OUT;
        sdata_nx = SDATA_OUT;
        latch_nx = LATCH_OUT;
        done_nx  = 1'b0;
        ready_nx = (state_nx == IDLE);
        unique case (state)
            IDLE: begin
                cnt_nx   = 9'd0;
                latch_nx = 1'b0;
                if (CMD_VALID) begin
                    word_nx  = {CMD_INST, CMD_ADDR};
                    bidx_nx  = 3'd0;
                    sclk_nx  = 1'b0;
                    sdata_nx = CMD_INST[1];
                end
            end
            SHIFT: begin
                if (full_hit) begin
                    cnt_nx  = 9'd0;
                    sclk_nx = 1'b0;
                    if (bidx == LAST_BIT) begin
                        sdata_nx = 1'b0;
                        latch_nx = 1'b1;
                    end else begin
                        bidx_nx  = bidx + 3'd1;
                        word_nx  = {word[5:0], 1'b0};
                        sdata_nx = word[5];
                    end
                end else if (half_hit) begin
                    sclk_nx = 1'b1;
                end
            end
            LATCH: begin
                if (full_hit) begin
                    cnt_nx   = 9'd0;
                    latch_nx = 1'b0;
                end
            end
            GAP: begin
                if (half_hit) begin
                    cnt_nx  = 9'd0;
                    done_nx = 1'b1;
                end
            end
            default: begin
                cnt_nx   = 9'd0;
                sclk_nx  = 1'b0;
                sdata_nx = 1'b0;
                latch_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt       <= 9'd0;
            bidx      <= 3'd0;
            word      <= 7'd0;
            SCLK_OUT  <= 1'b0;
            SDATA_OUT <= 1'b0;
            LATCH_OUT <= 1'b0;
            DONE      <= 1'b0;
            CMD_READY <= 1'b1;
        end else begin
            cnt       <= cnt_nx;
            bidx      <= bidx_nx;
            word      <= word_nx;
            SCLK_OUT  <= sclk_nx;
            SDATA_OUT <= sdata_nx;
            LATCH_OUT <= latch_nx;
            DONE      <= done_nx;
            CMD_READY <= ready_nx;
        end
    end

    // Blink wave runs on its own, untouched by frame traffic.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pcnt        <= 24'd0;
            PATTERN_OUT <= 1'b0;
        end else if (pcnt == PAT_END) begin
            pcnt        <= 24'd0;
            PATTERN_OUT <= ~PATTERN_OUT;
        end else begin
            pcnt <= pcnt + 24'd1;
        end
    end

endmodule

// File: doc/led_cmd_tx.md
LED_CMD_TX -- requirements
Module: led_cmd_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: serial clock half-period in CLK cycles; legal range 1..255.
REQ-002 Parameter PAT_DIV, default 1000000: PATTERN_OUT half-period in CLK cycles; legal range 1..2^24-1.
REQ-003 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-low reset.
REQ-005 CMD_VALID  in  1  host command valid.
REQ-006 CMD_READY  out  1  block accepts a command this cycle.
REQ-007 CMD_ADDR  in  5  LED address; receiver decodes 0..15.
REQ-008 CMD_INST  in  2  bit0 = active, bit1 = pattern-enable.
REQ-009 SCLK_OUT  out  1  serial clock to the receiver.
REQ-010 SDATA_OUT  out  1  serial data to the receiver.
REQ-011 LATCH_OUT  out  1  latch strobe to the receiver.
REQ-012 PATTERN_OUT  out  1  free-running blink square wave to the receiver PATTERN input.
REQ-013 DONE  out  1  one-cycle pulse when a frame completes.

Function
REQ-014 All outputs SHALL be registered; CMD_READY SHALL be 1 exactly when the state is IDLE.
REQ-015 Frame word SHALL be W[6:0] = {CMD_INST[1:0], CMD_ADDR[4:0]}, captured at acceptance and held stable for the whole frame; CMD_ADDR values 16..31 SHALL be sent unchanged.
REQ-016 Acceptance SHALL occur on a rising edge where RESET=1, CMD_VALID=1 and CMD_READY=1 (edge T0).
REQ-017 States: IDLE -> SHIFT -> LATCH -> GAP -> IDLE; there are no other transitions except reset.
REQ-018 SHIFT SHALL send W[6] first and W[0] last; each bit SHALL be a low phase of CLK_DIV cycles (SCLK_OUT=0, SDATA_OUT=bit) followed by a high phase of CLK_DIV cycles (SCLK_OUT=1, SDATA_OUT unchanged).
REQ-019 SDATA_OUT SHALL change only in the same cycle that SCLK_OUT goes low, so data is stable for at least CLK_DIV cycles before each SCLK_OUT rising edge.
REQ-020 The first low phase SHALL start the cycle after T0; exactly 7 SCLK_OUT rising edges SHALL occur per frame.
REQ-021 LATCH: SCLK_OUT=0, SDATA_OUT=0 and LATCH_OUT=1 for 2*CLK_DIV cycles.
REQ-022 GAP: LATCH_OUT=0 for CLK_DIV cycles; DONE SHALL pulse in the final GAP cycle.
REQ-023 CMD_READY SHALL return to 1 exactly 17*CLK_DIV cycles after T0.
REQ-024 LATCH_OUT SHALL never be 1 while SCLK_OUT=1 or during SHIFT.
REQ-025 CMD_VALID and command inputs SHALL be ignored outside IDLE; there is no queueing.
REQ-026 A command held valid continuously SHALL be re-accepted on the first IDLE cycle after DONE, producing back-to-back frames.
REQ-027 PATTERN_OUT SHALL toggle every PAT_DIV cycles from a 24-bit counter, independent of the frame FSM and of CMD traffic.

Reset
REQ-028 At any rising edge with RESET=0: state=IDLE; bit index and all counters = 0; SCLK_OUT=SDATA_OUT=LATCH_OUT=DONE=PATTERN_OUT=0; CMD_READY=1 from the following cycle.
REQ-029 No command SHALL be accepted on an edge where RESET=0.
REQ-030 Reset during SHIFT, LATCH or GAP SHALL abort the frame with no LATCH_OUT pulse and no DONE pulse.

Verification
REQ-031 CLK_DIV=4, accept ADDR=5, INST=2'b11 -> SDATA_OUT sampled at SCLK_OUT rising edges = 1,1,0,0,1,0,1; LATCH_OUT high 8 cycles; DONE at T0+68; CMD_READY=1 at T0+68.
REQ-032 CLK_DIV=1, ADDR=15, INST=2'b01 -> bits 0,1,0,1,1,1,1; each SCLK_OUT phase 1 cycle; CMD_READY=1 at T0+17.
REQ-033 CMD_VALID held high with ADDR=0 then ADDR=31 changed mid-frame -> first frame sends 0000000; second frame (accepted right after DONE) sends 0011111.
REQ-034 RESET=0 asserted at T0+10 (CLK_DIV=4) -> all outputs 0 next cycle; no LATCH_OUT or DONE; after RESET=1 a new command transmits correctly.
REQ-035 PAT_DIV=3 over 20 cycles with command traffic -> PATTERN_OUT period 6 cycles, unaffected by frames.
REQ-036 Assertion checks on all tests: LATCH_OUT and SCLK_OUT never both 1; SDATA_OUT stable whenever SCLK_OUT=1.
